lsu_mem_unit: RTL and testbench
===============================

// Module: lsu_mem_unit
// PURPOSE
// - Parametrised LSU execute/memory stage: accepts one decoded load/store per valid/ready handshake, forms
//   address rs1+sext(imm) with operand forwarding, drives a req/gnt + rvalid memory port, aligns/extends load data.
// - Sits between LSU issue slot and register writeback; single outstanding access, blocks issue until done.
// PARAMETERS
// - XLEN        32  data/address width; 32 or 64 (size 2'b11 = doubleword legal only when XLEN==64)
// - IMM_W       12  immediate width, sign-extended to XLEN
// - REG_AW      5   destination register index width
// PORTS
// - clk            in   1        clock, all state on rising edge
// - rst_n          in   1        asynchronous active-low reset
// - in_valid       in   1        op valid; in_ready out 1: accept when both high
// - in_is_load     in   1        1=load, 0=store
// - in_unsigned    in   1        load zero-extends when 1, sign-extends when 0
// - in_size        in   2        00 byte, 01 half, 10 word, 11 dword
// - in_rd          in   REG_AW   load destination register
// - in_imm         in   IMM_W    offset; rs1/rs2_data, rs1/rs2_fwd_data in XLEN; is_rs1/rs2_fwd in 1 (fwd select)
// - flush          in   1        squash pending op
// - mem_req/mem_we out  1        request, write enable; mem_gnt in 1: request accepted
// - mem_addr       out  XLEN     byte address; mem_wdata out XLEN lane-replicated; mem_be out XLEN/8 byte enables
// - mem_rvalid     in   1        load response strobe; mem_rdata in XLEN; mem_err in 1 (bus error, with rvalid)
// - wb_valid       out  1        one-cycle load writeback; wb_rd REG_AW; wb_data XLEN
// - exc_valid      out  1        one-cycle exception; exc_cause 2 (01 misaligned, 10 bus err, 11 illegal size); exc_addr XLEN
// BEHAVIOUR
// - Reset: state IDLE; mem_req, mem_we, wb_valid, exc_valid =0; mem_addr, mem_wdata, mem_be, wb_*, exc_* =0.
// - FSM IDLE -> REQ -> (store: IDLE on gnt | load: WAIT_RSP on gnt) -> IDLE on rvalid. in_ready = (state==IDLE).
// - Accept in cycle N: address computed combinationally from forwarded operands, all mem_* registered; mem_req high from N+1.
// - mem_req, mem_addr, mem_we, mem_wdata, mem_be held stable until mem_gnt; gnt in same cycle as req completes it.
// - Store done on gnt: back to IDLE, in_ready high next cycle; no writeback. Min store occupancy 2 cycles.
// - Load: rvalid at cycle M -> wb_valid=1 at M+1 with data = (rdata >> 8*addr_lo) truncated to size, extended per in_unsigned.
// - mem_be = ((1<<bytes)-1) << addr_lo; mem_wdata = rs2 low bytes replicated across all lanes.
// - Address arithmetic modulo 2^XLEN (wraps, no overflow flag).
// - Illegal size (11 with XLEN==32): no memory access; exc_valid cause 11 at N+1; stays IDLE.
// - mem_err with rvalid: no wb_valid; exc_valid cause 10, exc_addr = request address, at M+1.
// - flush in IDLE/REQ (before gnt): drop mem_req next cycle, return IDLE, no wb/exc. flush in WAIT_RSP: keep waiting for
//   rvalid, suppress wb_valid/exc_valid for that response. flush and in_valid same cycle: flush wins, op not accepted.
// - rvalid in any state other than WAIT_RSP is ignored. No combinational path in_* -> mem_*.
// CONFIGURATION
// - LSU_MISALIGN_TRAP_EN defined: misaligned legal-size op -> no memory access, exc_valid cause 01, exc_addr = unaligned
//   address, at N+1; state stays IDLE.
// - Undefined: misaligned address silently aligned down (low log2(bytes) bits cleared) and issued normally; no cause 01.
// STRUCTURE
// - lsu_pkg: lsu_size_e, lsu_state_e {IDLE,REQ,WAIT_RSP}, exc cause localparams, function size_bytes(size).
// - Sub-module lsu_load_align: combinational lane extract + sign/zero extend (rdata, addr_lo, size, unsigned -> data).
// - Top holds FSM, request registers, pending load context (rd, size, unsigned, addr_lo, flushed bit).
// TESTING
// - Load word: rs1=0x1000, imm=0x004, rvalid+rdata=0xDEADBEEF 3 cycles after gnt -> mem_addr=0x1004, be=4'b1111,
//   wb_valid one cycle later, wb_data=0xDEADBEEF.
// - Signed byte load: addr 0x2003, rdata=0x80FFFFFF -> be=4'b1000, wb_data=0xFFFFFF80; unsigned -> 0x00000080.
// - Store half, rs1 fwd=0x3000 (rs1_data=0), imm=0xFFE, rs2=0x1234, gnt delayed 4 cycles -> addr=0x2FFE, be=4'b1100,
//   wdata=0x12341234, req/addr stable until gnt, in_ready high cycle after gnt.
// - Misaligned word addr 0x1002: with LSU_MISALIGN_TRAP_EN -> no mem_req, exc cause 01 addr 0x1002; without -> addr 0x1000.
// - Flush during WAIT_RSP then rvalid -> no wb_valid, no exc, in_ready high next cycle; flush before gnt -> req dropped.
// - mem_err on load at 0x4000 -> exc_valid cause 10 exc_addr 0x4000, wb_valid stays 0; rst_n low mid-REQ -> all outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg: shared types, exception causes and size helper for the LSU stage.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ      = 2'b01,
    WAIT_RSP = 2'b10
  } lsu_state_e;

  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUS_ERR  = 2'b10;
  localparam logic [1:0] EXC_ILL_SIZE = 2'b11;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align: extracts the addressed lanes of a load response and
// sign/zero-extends them to XLEN. Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LO_W = 2
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [LO_W-1:0] addr_lo_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep_mask;
  logic [XLEN-1:0] top_bit;
  logic [6:0]      nbits;
  logic            sign;

  always_comb begin
    shifted   = rdata_i >> {addr_lo_i, 3'b000};
    nbits     = {size_bytes(size_i), 3'b000};
    // A full-width access shifts the ones out completely, so the mask is all ones.
    keep_mask = ~({XLEN{1'b1}} << nbits);
    top_bit   = {{(XLEN-1){1'b0}}, 1'b1} << (nbits - 7'd1);
    sign      = !unsigned_i && (|(shifted & top_bit));
    data_o    = (shifted & keep_mask) | (sign ? ~keep_mask : '0);
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_unit.sv
// ---------------------------------------------------------------------------
// lsu_mem_unit: single-outstanding load/store execute stage with req/gnt +
// rvalid memory port. Define LSU_MISALIGN_TRAP_EN to trap misaligned ops
// instead of aligning them down. Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_mem_unit
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IMM_W  = 12,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_is_load_i,
  input  logic              in_unsigned_i,
  input  logic [1:0]        in_size_i,
  input  logic [REG_AW-1:0] in_rd_i,
  input  logic [IMM_W-1:0]  in_imm_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   rs1_fwd_data_i,
  input  logic [XLEN-1:0]   rs2_fwd_data_i,
  input  logic              is_rs1_fwd_i,
  input  logic              is_rs2_fwd_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  input  logic              mem_gnt_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_be_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              mem_err_i,
  output logic              wb_valid_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              exc_valid_o,
  output logic [1:0]        exc_cause_o,
  output logic [XLEN-1:0]   exc_addr_o
);

  localparam int BE_W = XLEN / 8;
  localparam int LO_W = $clog2(BE_W);

  lsu_state_e        state_q;
  logic              mem_req_q, mem_we_q;
  logic [XLEN-1:0]   mem_addr_q, mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;
  logic              wb_valid_q, exc_valid_q;
  logic [REG_AW-1:0] wb_rd_q, rd_q;
  logic [XLEN-1:0]   wb_data_q, exc_addr_q;
  logic [1:0]        exc_cause_q, size_q;
  logic              unsigned_q, flushed_q;
  logic [LO_W-1:0]   addr_lo_q;

  logic [XLEN-1:0]   rs1_eff, rs2_eff, imm_sext, eff_addr, req_addr, req_wdata, load_data;
  logic [3:0]        req_bytes, bytes_m1;
  logic [LO_W-1:0]   lo_mask;
  logic [BE_W-1:0]   be_base, req_be;
  logic              illegal_size, trap_misalign;

  always_comb begin
    rs1_eff      = is_rs1_fwd_i ? rs1_fwd_data_i : rs1_data_i;
    rs2_eff      = is_rs2_fwd_i ? rs2_fwd_data_i : rs2_data_i;
    imm_sext     = {{(XLEN-IMM_W){in_imm_i[IMM_W-1]}}, in_imm_i};
    eff_addr     = rs1_eff + imm_sext;
    req_bytes    = size_bytes(in_size_i);
    bytes_m1     = req_bytes - 4'd1;
    lo_mask      = bytes_m1[LO_W-1:0];
    illegal_size = (in_size_i == SIZE_D) && (XLEN != 64);
    req_addr     = {eff_addr[XLEN-1:LO_W], eff_addr[LO_W-1:0] & ~lo_mask};
    be_base      = ~({BE_W{1'b1}} << req_bytes);
    req_be       = be_base << req_addr[LO_W-1:0];
    case (in_size_i)
      SIZE_B:  req_wdata = {(XLEN/8){rs2_eff[7:0]}};
      SIZE_H:  req_wdata = {(XLEN/16){rs2_eff[15:0]}};
      SIZE_W:  req_wdata = {(XLEN/32){rs2_eff[31:0]}};
      default: req_wdata = rs2_eff;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    trap_misalign = |(eff_addr[LO_W-1:0] & lo_mask);
`else
    trap_misalign = 1'b0;
`endif
  end

  lsu_load_align #(
    .XLEN(XLEN),
    .LO_W(LO_W)
  ) u_load_align (
    .rdata_i   (mem_rdata_i),
    .addr_lo_i (addr_lo_q),
    .size_i    (size_q),
    .unsigned_i(unsigned_q),
    .data_o    (load_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= 2'b00;
      exc_addr_q  <= '0;
      rd_q        <= '0;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      addr_lo_q   <= '0;
      flushed_q   <= 1'b0;
    end else begin
      wb_valid_q  <= 1'b0;
      exc_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A flush in the same cycle as in_valid discards the op.
          if (in_valid_i && !flush_i) begin
            if (illegal_size) begin
              exc_valid_q <= 1'b1;
              exc_cause_q <= EXC_ILL_SIZE;
              exc_addr_q  <= eff_addr;
            end else if (trap_misalign) begin
              exc_valid_q <= 1'b1;
              exc_cause_q <= EXC_MISALIGN;
              exc_addr_q  <= eff_addr;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= !in_is_load_i;
              mem_addr_q  <= req_addr;
              mem_wdata_q <= req_wdata;
              mem_be_q    <= req_be;
              rd_q        <= in_rd_i;
              size_q      <= in_size_i;
              unsigned_q  <= in_unsigned_i;
              addr_lo_q   <= req_addr[LO_W-1:0];
              flushed_q   <= 1'b0;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          if (flush_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= IDLE;
          end else if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= mem_we_q ? IDLE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            state_q <= IDLE;
            if (!(flushed_q || flush_i)) begin
              if (mem_err_i) begin
                exc_valid_q <= 1'b1;
                exc_cause_q <= EXC_BUS_ERR;
                exc_addr_q  <= mem_addr_q;
              end else begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= rd_q;
                wb_data_q  <= load_data;
              end
            end
          end else if (flush_i) begin
            flushed_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign exc_valid_o = exc_valid_q;
  assign exc_cause_o = exc_cause_q;
  assign exc_addr_o  = exc_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_unit: directed scoreboard bench for lsu_mem_unit (XLEN=32).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu_mem_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_is_load = 1'b0, in_unsigned = 1'b0;
  logic [1:0]  in_size = 2'b00;
  logic [4:0]  in_rd = '0;
  logic [11:0] in_imm = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0, rs1_fwd = '0, rs2_fwd = '0;
  logic        is_rs1_fwd = 1'b0, is_rs2_fwd = 1'b0, flush = 1'b0;
  logic        mem_req, mem_we, mem_gnt = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [1:0]  exc_cause;

  always #5 clk = ~clk;

  lsu_mem_unit #(.XLEN(32), .IMM_W(12), .REG_AW(5)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_is_load_i(in_is_load),
    .in_unsigned_i(in_unsigned), .in_size_i(in_size), .in_rd_i(in_rd), .in_imm_i(in_imm),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .rs1_fwd_data_i(rs1_fwd),
    .rs2_fwd_data_i(rs2_fwd), .is_rs1_fwd_i(is_rs1_fwd), .is_rs2_fwd_i(is_rs2_fwd),
    .flush_i(flush), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_gnt_i(mem_gnt),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .exc_valid_o(exc_valid), .exc_cause_o(exc_cause), .exc_addr_o(exc_addr)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          kind;  // 0 nothing, 1 writeback, 2 exception
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  cause;
    logic [31:0] addr;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  int checks = 0, errors = 0;
  int wb_cnt = 0, exc_cnt = 0, exp_wb = 0, exp_exc = 0;

  logic [4:0]  pend_rd;
  logic [1:0]  pend_sz;
  logic        pend_uns, pend_flushed;
  logic [1:0]  pend_lo;
  logic [31:0] pend_addr;

  always @(negedge clk) begin
    if (wb_valid) wb_cnt++;
    if (exc_valid) exc_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic uns, input logic [1:0] sz, input logic [4:0] rd,
                       input logic [31:0] rs1, input logic sel, input logic [31:0] fwd,
                       input logic [11:0] imm, input logic [31:0] rs2);
    logic [31:0] ea, al, lomask;
    logic        trap_en, mis;
    req_t        r;
    ea = (sel ? fwd : rs1) + {{20{imm[11]}}, imm};
    case (sz)
      2'd0:    lomask = 32'd0;
      2'd1:    lomask = 32'd1;
      default: lomask = 32'd3;
    endcase
    mis = (ea & lomask) != 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    in_valid = 1'b1; in_is_load = ld; in_unsigned = uns; in_size = sz; in_rd = rd;
    rs1_data = rs1; is_rs1_fwd = sel; rs1_fwd = fwd; in_imm = imm; rs2_data = rs2;
    chk("in_ready_at_issue", in_ready, 1);
    cyc();
    in_valid = 1'b0; is_rs1_fwd = 1'b0;
    if (sz == 2'd3) begin
      exp_exc++;
      chk("ill_exc_valid", exc_valid, 1);
      chk("ill_exc_cause", exc_cause, 2'b11);
      chk("ill_exc_addr", exc_addr, ea);
      chk("ill_no_req", mem_req, 0);
      chk("ill_ready", in_ready, 1);
    end else if (trap_en && mis) begin
      exp_exc++;
      chk("mis_exc_valid", exc_valid, 1);
      chk("mis_exc_cause", exc_cause, 2'b01);
      chk("mis_exc_addr", exc_addr, ea);
      chk("mis_no_req", mem_req, 0);
    end else begin
      al = ea & ~lomask;
      r.addr = al;
      r.we   = !ld;
      case (sz)
        2'd0:    begin r.be = 4'b0001 << al[1:0]; r.wdata = {4{rs2[7:0]}}; end
        2'd1:    begin r.be = 4'b0011 << al[1:0]; r.wdata = {2{rs2[15:0]}}; end
        default: begin r.be = 4'b1111;            r.wdata = rs2; end
      endcase
      req_q.push_back(r);
      chk("req_raised", mem_req, 1);
      chk("busy_after_issue", in_ready, 0);
      pend_rd = rd; pend_sz = sz; pend_uns = uns; pend_lo = al[1:0];
      pend_addr = al; pend_flushed = 1'b0;
    end
  endtask

  task automatic grant(input int delay);
    req_t e;
    if (req_q.size() == 0) begin
      chk("req_scoreboard_empty", 1, 0);
      return;
    end
    e = req_q.pop_front();
    for (int i = 0; i < delay; i++) begin
      chk("req_held", mem_req, 1);
      chk("addr_held", mem_addr, e.addr);
      chk("be_held", mem_be, e.be);
      cyc();
    end
    chk("req_addr", mem_addr, e.addr);
    chk("req_we", mem_we, e.we);
    chk("req_be", mem_be, e.be);
    chk("req_wdata", mem_wdata, e.wdata);
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    chk("req_dropped_after_gnt", mem_req, 0);
    chk("ready_after_gnt", in_ready, e.we);
  endtask

  task automatic respond(input int delay, input logic [31:0] rdata, input logic err);
    rsp_t        e;
    logic [31:0] sh;
    for (int i = 0; i < delay; i++) cyc();
    e.kind = 0; e.rd = '0; e.data = '0; e.cause = 2'b00; e.addr = '0;
    if (pend_flushed) begin
      e.kind = 0;
    end else if (err) begin
      e.kind = 2; e.cause = 2'b10; e.addr = pend_addr; exp_exc++;
    end else begin
      e.kind = 1; e.rd = pend_rd; exp_wb++;
      sh = rdata >> (8 * pend_lo);
      case (pend_sz)
        2'd0:    e.data = pend_uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
        2'd1:    e.data = pend_uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        default: e.data = sh;
      endcase
    end
    rsp_q.push_back(e);
    mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
    cyc();
    mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    e = rsp_q.pop_front();
    chk("rsp_wb_valid", wb_valid, e.kind == 1);
    chk("rsp_exc_valid", exc_valid, e.kind == 2);
    if (e.kind == 1) begin
      chk("rsp_wb_rd", wb_rd, e.rd);
      chk("rsp_wb_data", wb_data, e.data);
    end
    if (e.kind == 2) begin
      chk("rsp_exc_cause", exc_cause, e.cause);
      chk("rsp_exc_addr", exc_addr, e.addr);
    end
    chk("ready_after_rsp", in_ready, 1);
    pend_flushed = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    cyc();

    // Load word 0x1004
    issue(1, 0, 2'd2, 5'd5, 32'h1000, 0, 32'h0, 12'h004, 32'h0);
    grant(1);
    respond(3, 32'hDEADBEEF, 0);

    // Signed and unsigned byte at 0x2003
    issue(1, 0, 2'd0, 5'd6, 32'h2000, 0, 32'h0, 12'h003, 32'h0);
    grant(0);
    respond(0, 32'h80FFFFFF, 0);
    issue(1, 1, 2'd0, 5'd7, 32'h2000, 0, 32'h0, 12'h003, 32'h0);
    grant(2);
    respond(1, 32'h80FFFFFF, 0);

    // Signed halfword in upper lanes
    issue(1, 0, 2'd1, 5'd8, 32'h2002, 0, 32'h0, 12'h000, 32'h0);
    grant(0);
    respond(0, 32'h9ABC0000, 0);

    // Store half through forwarded rs1 with a slow grant
    issue(0, 0, 2'd1, 5'd0, 32'h0, 1, 32'h3000, 12'hFFE, 32'h1234);
    chk("st_addr_2ffe", mem_addr, 32'h2FFE);
    grant(4);

    // Misaligned word at 0x1002
    issue(1, 0, 2'd2, 5'd9, 32'h1000, 0, 32'h0, 12'h002, 32'h0);
`ifndef LSU_MISALIGN_TRAP_EN
    grant(0);
    respond(1, 32'h11223344, 0);
`endif

    // Doubleword is illegal at XLEN=32
    issue(1, 0, 2'd3, 5'd10, 32'h1000, 0, 32'h0, 12'h000, 32'h0);

    // Flush before grant drops the request
    issue(1, 0, 2'd2, 5'd11, 32'h5000, 0, 32'h0, 12'h000, 32'h0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_req_dropped", mem_req, 0);
    chk("flush_ready", in_ready, 1);
    req_q.delete();

    // Flush while waiting suppresses the response
    issue(1, 0, 2'd2, 5'd12, 32'h6000, 0, 32'h0, 12'h000, 32'h0);
    grant(0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_wait_busy", in_ready, 0);
    pend_flushed = 1'b1;
    respond(2, 32'hCAFEF00D, 0);

    // Stray rvalid in IDLE
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    cyc();
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk("stray_rvalid_no_wb", wb_valid, 0);
    chk("stray_rvalid_ready", in_ready, 1);

    // Bus error on load at 0x4000
    issue(1, 0, 2'd2, 5'd13, 32'h4000, 0, 32'h0, 12'h000, 32'h0);
    grant(0);
    respond(1, 32'h0, 1);

    // Flush and in_valid together: op dropped
    in_valid = 1'b1; flush = 1'b1; in_is_load = 1'b0; in_size = 2'd2;
    rs1_data = 32'h8000; in_imm = 12'h000; rs2_data = 32'h55;
    cyc();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_valid_no_req", mem_req, 0);
    chk("flush_valid_ready", in_ready, 1);

    // Address wraps modulo 2^32
    issue(1, 0, 2'd2, 5'd14, 32'hFFFFFFFC, 0, 32'h0, 12'h008, 32'h0);
    chk("wrap_addr", mem_addr, 32'h4);
    grant(0);
    respond(0, 32'h0BADF00D, 0);

    // Asynchronous reset in the middle of a request
    issue(0, 0, 2'd0, 5'd0, 32'h7000, 0, 32'h0, 12'h001, 32'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_be", mem_be, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_wb_data", wb_data, 0);
    chk("midrst_exc_addr", exc_addr, 0);
    chk("midrst_ready", in_ready, 1);
    req_q.delete();
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    chk("wb_pulse_count", wb_cnt, exp_wb);
    chk("exc_pulse_count", exc_cnt, exp_exc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
